missile_pool: RTL and testbench
===============================

# missile_pool

Parametrised multi-missile controller for the tank: owns a pool of `NUM_MISSILES` independent projectile slots, allocates a free slot on each new fire request, moves every active missile once per frame in sub-pixel fixed point, and retires missiles on per-slot collision or on leaving the screen. It sits between the keyboard/tank logic and the per-missile bitmap/collision blocks, and replaces the single-shot missile mover with multi-shot, cooldown and auto-retire behaviour.

## Interface
- `NUM_MISSILES`, 4: number of slots, 1..8.
- `SPEED`, 300: per-frame displacement in sub-pixel units (1/2^`FRAC_BITS` pixel).
- `FRAC_BITS`, 6: fractional bits of the internal position.
- `COOLDOWN_FRAMES`, 8: frames after an accepted shot during which new shots are refused. 0 disables the cooldown.
- `X_MAX`, 639: largest legal topLeftX in pixels.
- `Y_MAX`, 479: largest legal topLeftY in pixels.

- `clk` in 1: system clock.
- `resetN` in 1: reset, synchronous, active-low.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `fireReq` in 1: shoot key level. Only its rising edge fires.
- `tankTopLeftX` in 11: spawn X in pixels.
- `tankTopLeftY` in 11: spawn Y in pixels.
- `tankDir` in 2: spawn direction. 00 up, 01 right, 10 down, 11 left.
- `collision` in `NUM_MISSILES`: per-slot hit, sampled every clock.
- `topLeftX` out 11×`NUM_MISSILES`: packed pixel X. Slot i occupies bits [11i+10:11i].
- `topLeftY` out 11×`NUM_MISSILES`: packed pixel Y, same packing.
- `drawEn` out `NUM_MISSILES`: slot active.
- `fireAck` out 1: one-cycle pulse when a shot is accepted.
- `activeCount` out 4: number of active slots.

## Operation
- **Per-slot state:** active bit, signed positions posX/posY of width 11+`FRAC_BITS`+1, signed velocities velX/velY.
- **Global state:** `fireReq_d` register and a cooldown counter.
- **Edge detect:** `fireEdge = fireReq & ~fireReq_d`. `fireReq_d` updates every clock. A held key fires exactly once.
- **Accept condition:** `fireEdge` and `cooldown == 0` and at least one inactive slot.
  - The target is the lowest-index inactive slot.
  - A refused edge is dropped. It is not queued.
- **On accept, for slot k:**
  - active ← 1.
  - posX ← `tankTopLeftX` << `FRAC_BITS`; posY ← `tankTopLeftY` << `FRAC_BITS`.
  - Velocity by direction: up (0, −SPEED); right (+SPEED, 0); down (0, +SPEED); left (−SPEED, 0).
  - cooldown ← `COOLDOWN_FRAMES`.
  - `fireAck` registered to 1.
- **Cooldown:** decrements by 1 on each `startOfFrame` while nonzero. An accept in the same cycle reloads it; the reload wins.
- **Movement:** on `startOfFrame`, each active slot not colliding and not being loaded this cycle computes next = pos + vel.
  - If nextX < 0, nextX > `X_MAX`<<`FRAC_BITS`, nextY < 0, or nextY > `Y_MAX`<<`FRAC_BITS`, the slot retires: active ← 0 and the position is not updated.
  - Otherwise pos ← next.
- **Collision:** `collision[i]` on an active slot retires it that clock. It has priority over movement. `collision[i]` on an inactive slot is ignored.
- **Outputs:**
  - `topLeftX[i]` = posX[i] >>> `FRAC_BITS`, truncated to 11 bits, when active; 0 when inactive. `topLeftY` is the same.
  - `drawEn[i]` = active[i].
  - `activeCount` = popcount(active), combinational from registers.

## Timing
- **Reset:** all state is cleared on a clock edge with `resetN` = 0.
  - All slots inactive, positions and velocities 0, cooldown 0, `fireReq_d` 0.
  - Outputs: `drawEn` = 0, `topLeftX`/`topLeftY` = 0, `fireAck` = 0, `activeCount` = 0.
  - A reset mid-flight kills all missiles at that edge.
- **Fire latency:** with the `fireReq` rise sampled at edge n, `drawEn[k]`, spawn coordinates and `fireAck` are visible after edge n. `fireAck` is high exactly one cycle.
- **First move:** the first displacement happens at the first `startOfFrame` strictly after the load edge. Fire and `startOfFrame` in the same cycle loads the spawn position only.
- **Slot reuse:** a slot retired at edge n is allocatable from edge n+1 onward. Simultaneous retire of slot j and fire never allocates slot j in that cycle.
- **Multiple collisions:** several collisions in one cycle each retire their own slot.
- **Pool full:** a fire edge is refused. `fireAck` stays 0 and no state changes except `fireReq_d`.

## Test plan
- **Reset and single shot:** reset, then tank (100,200), dir 01, `fireReq` rise → next cycle `fireAck`=1, `drawEn`=0001, slot 0 at (100,200). After 3 frames: X = (6400+900)>>6 = 114, Y = 200.
- **Held key and cooldown:** `fireReq` held 20 frames → one shot. Release and re-press at frame 4 → refused. Re-press at frame 9 → slot 1 allocated, `fireAck` pulse.
- **Pool exhaustion:** `COOLDOWN_FRAMES`=0, five fire edges with 4 slots → `drawEn`=1111, fifth shot no `fireAck`, `activeCount`=4. Then `collision`=0100 → `drawEn`=1011, next fire fills slot 2.
- **Off-screen retire:** spawn (5,5), dir 00, SPEED=300 → Y sub-pixel 320→20. The next frame would give −280, so `drawEn[0]` falls at that `startOfFrame` and Y stays 0 on the output.
- **Simultaneous events:** collision[0] and `startOfFrame` on active slot 0 → retired, no move. Fire and `startOfFrame` same cycle → spawn position unchanged that frame. `collision` on an inactive slot → no effect.
- **Mid-flight reset:** three missiles active, `resetN` low for one edge → all outputs 0, cooldown cleared. An immediate fire after reset is accepted.

Source files
------------

// File: rtl/missile_pool.sv
// missile_pool: pool of independent missile slots for the tank.
// A new shot takes the lowest free slot. Every active missile moves once per frame
// in sub-pixel fixed point. A missile retires on its own collision or when it would
// leave the screen.
module missile_pool #(
  parameter int NUM_MISSILES    = 4,
  parameter int SPEED           = 300,
  parameter int FRAC_BITS       = 6,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       fireReq,
  input  logic [10:0]                tankTopLeftX,
  input  logic [10:0]                tankTopLeftY,
  input  logic [1:0]                 tankDir,
  input  logic [NUM_MISSILES-1:0]    collision,
  output logic [11*NUM_MISSILES-1:0] topLeftX,
  output logic [11*NUM_MISSILES-1:0] topLeftY,
  output logic [NUM_MISSILES-1:0]    drawEn,
  output logic                       fireAck,
  output logic [3:0]                 activeCount
);

  // Position carries a sign bit so that a step past the top/left edge shows up as negative.
  localparam int POS_W  = 11 + FRAC_BITS + 1;
  // The next-position sum gets one more bit so that pos + vel can never wrap.
  localparam int NEXT_W = POS_W + 1;
  localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic signed [POS_W-1:0]  SPEED_V = POS_W'(SPEED);
  localparam logic signed [NEXT_W-1:0] X_LIMIT = NEXT_W'(X_MAX * (2 ** FRAC_BITS));
  localparam logic signed [NEXT_W-1:0] Y_LIMIT = NEXT_W'(Y_MAX * (2 ** FRAC_BITS));

  logic [NUM_MISSILES-1:0]    active;
  logic signed [POS_W-1:0]    posX [NUM_MISSILES];
  logic signed [POS_W-1:0]    posY [NUM_MISSILES];
  logic signed [POS_W-1:0]    velX [NUM_MISSILES];
  logic signed [POS_W-1:0]    velY [NUM_MISSILES];
  logic                       fireReq_d;
  logic [CD_W-1:0]            cooldown;

  logic                       fireEdge;
  logic                       freeFound;
  logic                       accept;
  logic [NUM_MISSILES-1:0]    candVec;
  logic [NUM_MISSILES-1:0]    loadVec;
  logic signed [POS_W-1:0]    spawnX;
  logic signed [POS_W-1:0]    spawnY;
  logic signed [POS_W-1:0]    spawnVelX;
  logic signed [POS_W-1:0]    spawnVelY;
  logic signed [NEXT_W-1:0]   nextX [NUM_MISSILES];
  logic signed [NEXT_W-1:0]   nextY [NUM_MISSILES];
  logic [NUM_MISSILES-1:0]    offScreen;

  // Pick the lowest inactive slot and decide whether this cycle's fire edge is accepted.
  always_comb begin
    candVec   = '0;
    freeFound = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!active[i] && !freeFound) begin
        candVec[i] = 1'b1;
        freeFound  = 1'b1;
      end
    end
    fireEdge = fireReq & ~fireReq_d;
    accept   = fireEdge && (cooldown == '0) && freeFound;
    loadVec  = accept ? candVec : '0;
  end

  // Spawn position and velocity come from the tank position and facing direction.
  always_comb begin
    spawnX    = $signed({1'b0, tankTopLeftX, {FRAC_BITS{1'b0}}});
    spawnY    = $signed({1'b0, tankTopLeftY, {FRAC_BITS{1'b0}}});
    spawnVelX = '0;
    spawnVelY = '0;
    case (tankDir)
      2'b00:   spawnVelY = -SPEED_V;
      2'b01:   spawnVelX =  SPEED_V;
      2'b10:   spawnVelY =  SPEED_V;
      default: spawnVelX = -SPEED_V;
    endcase
  end

  // Candidate next position per slot, flagging any step that leaves the screen.
  always_comb begin
    for (int i = 0; i < NUM_MISSILES; i++) begin
      nextX[i]     = {posX[i][POS_W-1], posX[i]} + {velX[i][POS_W-1], velX[i]};
      nextY[i]     = {posY[i][POS_W-1], posY[i]} + {velY[i][POS_W-1], velY[i]};
      offScreen[i] = nextX[i][NEXT_W-1] || (nextX[i] > X_LIMIT) ||
                     nextY[i][NEXT_W-1] || (nextY[i] > Y_LIMIT);
    end
  end

  // Global state: fire edge history, acknowledge pulse and the shot cooldown.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fireReq_d <= 1'b0;
      fireAck   <= 1'b0;
      cooldown  <= '0;
    end else begin
      fireReq_d <= fireReq;
      fireAck   <= accept;
      if (accept)
        cooldown <= CD_W'(COOLDOWN_FRAMES);
      else if (startOfFrame && (cooldown != '0))
        cooldown <= cooldown - CD_W'(1);
    end
  end

  // Per-slot state. The load has priority, then the collision, then the frame move.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      active <= '0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        posX[i] <= '0;
        posY[i] <= '0;
        velX[i] <= '0;
        velY[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MISSILES; i++) begin
        if (loadVec[i]) begin
          active[i] <= 1'b1;
          posX[i]   <= spawnX;
          posY[i]   <= spawnY;
          velX[i]   <= spawnVelX;
          velY[i]   <= spawnVelY;
        end else if (active[i] && collision[i]) begin
          active[i] <= 1'b0;
        end else if (active[i] && startOfFrame) begin
          if (offScreen[i]) begin
            active[i] <= 1'b0;
          end else begin
            posX[i] <= nextX[i][POS_W-1:0];
            posY[i] <= nextY[i][POS_W-1:0];
          end
        end
      end
    end
  end

  // Pixel outputs are the integer part of the position. They are 0 while a slot is idle.
  always_comb begin
    topLeftX    = '0;
    topLeftY    = '0;
    activeCount = '0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (active[i]) begin
        topLeftX[11*i +: 11] = posX[i][FRAC_BITS +: 11];
        topLeftY[11*i +: 11] = posY[i][FRAC_BITS +: 11];
      end
      activeCount = activeCount + 4'(active[i]);
    end
    drawEn = active;
  end

endmodule

// File: tb/tb_missile_pool.sv
// tb_missile_pool: directed scoreboard bench for missile_pool with default parameters.
module tb_missile_pool;

  localparam int N     = 4;
  localparam int FRAC  = 6;
  localparam int SPEED = 300;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              fireReq;
  logic [10:0]       tankTopLeftX;
  logic [10:0]       tankTopLeftY;
  logic [1:0]        tankDir;
  logic [N-1:0]      collision;
  logic [11*N-1:0]   topLeftX;
  logic [11*N-1:0]   topLeftY;
  logic [N-1:0]      drawEn;
  logic              fireAck;
  logic [3:0]        activeCount;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expItem_t;

  expItem_t sbQ[$];
  int checks = 0;
  int errors = 0;

  // Free-running clock
  always #5 clk = ~clk;

  missile_pool #(
    .NUM_MISSILES(N), .SPEED(SPEED), .FRAC_BITS(FRAC),
    .COOLDOWN_FRAMES(8), .X_MAX(639), .Y_MAX(479)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
    .tankTopLeftX(tankTopLeftX), .tankTopLeftY(tankTopLeftY), .tankDir(tankDir),
    .collision(collision), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .drawEn(drawEn), .fireAck(fireAck), .activeCount(activeCount)
  );

  function automatic logic [31:0] slotX(input int i);
    return 32'(topLeftX[11*i +: 11]);
  endfunction

  function automatic logic [31:0] slotY(input int i);
    return 32'(topLeftY[11*i +: 11]);
  endfunction

  // Reference pixel coordinate after a number of frames at a signed sub-pixel velocity
  function automatic logic [31:0] expPix(input int spawn, input int frames, input int vel);
    int sub;
    sub = spawn * (2 ** FRAC) + frames * vel;
    return 32'(sub >>> FRAC);
  endfunction

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expItem_t item;
    item.tag   = tag;
    item.value = value;
    sbQ.push_back(item);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expItem_t item;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: observed %0d with no expected value queued", observed);
    end else begin
      item = sbQ.pop_front();
      assert (observed === item.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", item.tag, observed, item.value);
      end
    end
  endtask

  // Drive one clock of stimulus. Frame and collision are single-cycle pulses. Fire is a level.
  task automatic applyStimulus(input logic sof, input logic fire, input logic [N-1:0] coll);
    startOfFrame = sof;
    fireReq      = fire;
    collision    = coll;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    collision    = '0;
  endtask

  task automatic runFrames(input int n, input logic fire);
    for (int f = 0; f < n; f++) applyStimulus(1'b1, fire, '0);
  endtask

  task automatic setTank(input int x, input int y, input logic [1:0] dir);
    tankTopLeftX = 11'(x);
    tankTopLeftY = 11'(y);
    tankDir      = dir;
  endtask

  initial begin
    resetN = 1'b0;
    setTank(0, 0, 2'b00);
    startOfFrame = 1'b0;
    fireReq = 1'b0;
    collision = '0;

    // Reset state
    $display("[TB] reset");
    pushExpect("rst drawEn", 32'h0);
    pushExpect("rst activeCount", 32'h0);
    pushExpect("rst fireAck", 32'h0);
    pushExpect("rst topLeftX any", 32'h0);
    pushExpect("rst topLeftY any", 32'h0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));
    checkOutput(32'(fireAck));
    checkOutput(32'(|topLeftX));
    checkOutput(32'(|topLeftY));
    resetN = 1'b1;

    // Single shot to the right, key then held for 20 frames
    $display("[TB] single shot and held key");
    setTank(100, 200, 2'b01);
    pushExpect("shot0 fireAck", 32'h1);
    pushExpect("shot0 drawEn", 32'h1);
    pushExpect("shot0 X", 32'd100);
    pushExpect("shot0 Y", 32'd200);
    pushExpect("shot0 activeCount", 32'd1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(slotX(0));
    checkOutput(slotY(0));
    checkOutput(32'(activeCount));
    pushExpect("fireAck one cycle", 32'h0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    pushExpect("shot0 X 3 frames", 32'd114);
    pushExpect("shot0 Y 3 frames", 32'd200);
    runFrames(3, 1'b1);
    checkOutput(slotX(0));
    checkOutput(slotY(0));
    pushExpect("held activeCount", 32'd1);
    pushExpect("held X 20 frames", expPix(100, 20, SPEED));
    runFrames(17, 1'b1);
    checkOutput(32'(activeCount));
    checkOutput(slotX(0));
    applyStimulus(1'b0, 1'b0, '0);

    // Second shot downwards, then presses during the cooldown
    $display("[TB] cooldown");
    setTank(300, 100, 2'b10);
    pushExpect("shot1 fireAck", 32'h1);
    pushExpect("shot1 drawEn", 32'h3);
    pushExpect("shot1 X", 32'd300);
    pushExpect("shot1 Y", 32'd100);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(slotX(1));
    checkOutput(slotY(1));
    applyStimulus(1'b0, 1'b0, '0);
    runFrames(4, 1'b0);
    pushExpect("cooldown frame4 fireAck", 32'h0);
    pushExpect("cooldown frame4 drawEn", 32'h3);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    applyStimulus(1'b0, 1'b0, '0);
    runFrames(3, 1'b0);
    pushExpect("cooldown frame7 fireAck", 32'h0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    applyStimulus(1'b0, 1'b0, '0);
    pushExpect("shot1 Y 8 frames", expPix(100, 8, SPEED));
    pushExpect("shot0 X 28 frames", expPix(100, 28, SPEED));
    runFrames(1, 1'b0);
    checkOutput(slotY(1));
    checkOutput(slotX(0));

    // Fire together with a frame pulse: the spawn is not moved, other slots still move
    $display("[TB] fire with startOfFrame");
    setTank(50, 400, 2'b11);
    pushExpect("shot2 fireAck", 32'h1);
    pushExpect("shot2 drawEn", 32'h7);
    pushExpect("shot2 X", 32'd50);
    pushExpect("shot2 Y", 32'd400);
    pushExpect("shot1 Y 9 frames", expPix(100, 9, SPEED));
    applyStimulus(1'b1, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(slotX(2));
    checkOutput(slotY(2));
    checkOutput(slotY(1));
    applyStimulus(1'b0, 1'b0, '0);
    runFrames(7, 1'b0);
    pushExpect("reload wins fireAck", 32'h0);
    pushExpect("shot2 X 7 frames", expPix(50, 7, -SPEED));
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(slotX(2));
    applyStimulus(1'b0, 1'b0, '0);

    // Collision on an idle slot is ignored
    pushExpect("idle collision drawEn", 32'h7);
    pushExpect("idle collision activeCount", 32'd3);
    applyStimulus(1'b0, 1'b0, 4'b1000);
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));

    // Reset while three missiles are in flight, then an immediate shot
    $display("[TB] mid-flight reset");
    resetN = 1'b0;
    pushExpect("midrst drawEn", 32'h0);
    pushExpect("midrst activeCount", 32'h0);
    pushExpect("midrst topLeftX any", 32'h0);
    pushExpect("midrst topLeftY any", 32'h0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));
    checkOutput(32'(|topLeftX));
    checkOutput(32'(|topLeftY));
    resetN = 1'b1;
    setTank(5, 5, 2'b00);
    pushExpect("post-reset fireAck", 32'h1);
    pushExpect("post-reset drawEn", 32'h1);
    pushExpect("post-reset Y", 32'd5);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(slotY(0));
    applyStimulus(1'b0, 1'b0, '0);

    // Leaving the top of the screen retires the missile
    $display("[TB] off-screen retire");
    pushExpect("top edge Y", 32'd0);
    pushExpect("top edge drawEn", 32'h1);
    pushExpect("top edge X", 32'd5);
    runFrames(1, 1'b0);
    checkOutput(slotY(0));
    checkOutput(32'(drawEn));
    checkOutput(slotX(0));
    pushExpect("offscreen drawEn", 32'h0);
    pushExpect("offscreen topLeftY any", 32'h0);
    runFrames(1, 1'b0);
    checkOutput(32'(drawEn));
    checkOutput(32'(|topLeftY));

    // Collision together with a frame pulse retires the slot
    $display("[TB] collision with startOfFrame");
    runFrames(6, 1'b0);
    setTank(100, 200, 2'b01);
    pushExpect("shot3 fireAck", 32'h1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    applyStimulus(1'b0, 1'b0, '0);
    pushExpect("collide drawEn", 32'h0);
    pushExpect("collide activeCount", 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));

    // Fill the pool, then try a fifth shot
    $display("[TB] pool exhaustion");
    runFrames(7, 1'b0);
    for (int k = 0; k < N; k++) begin
      pushExpect("fill fireAck", 32'h1);
      pushExpect("fill drawEn", 32'((1 << (k + 1)) - 1));
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput(32'(fireAck));
      checkOutput(32'(drawEn));
      applyStimulus(1'b0, 1'b0, '0);
      runFrames(8, 1'b0);
    end
    pushExpect("full fireAck", 32'h0);
    pushExpect("full drawEn", 32'hF);
    pushExpect("full activeCount", 32'd4);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));
    applyStimulus(1'b0, 1'b0, '0);
    pushExpect("hit slot2 drawEn", 32'hB);
    pushExpect("hit slot2 activeCount", 32'd3);
    applyStimulus(1'b0, 1'b0, 4'b0100);
    checkOutput(32'(drawEn));
    checkOutput(32'(activeCount));
    pushExpect("refill fireAck", 32'h1);
    pushExpect("refill drawEn", 32'hF);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    applyStimulus(1'b0, 1'b0, '0);
    runFrames(8, 1'b0);

    // A slot retiring in the same cycle as a fire edge is not reused that cycle
    $display("[TB] retire and fire together");
    pushExpect("same-cycle fireAck", 32'h0);
    pushExpect("same-cycle drawEn", 32'hD);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    applyStimulus(1'b0, 1'b0, '0);
    pushExpect("reuse fireAck", 32'h1);
    pushExpect("reuse drawEn", 32'hF);
    pushExpect("reuse slot1 X", 32'd100);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(32'(fireAck));
    checkOutput(32'(drawEn));
    checkOutput(slotX(1));
    applyStimulus(1'b0, 1'b0, '0);

    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: %0d expected values never compared", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
